btb_predictor: RTL

//  Fetch-stage branch target buffer with 2-bit saturating direction counters, upstream of the pipelined ARM core.

---
 rtl/arm_bp_pkg.sv | 16 +
 rtl/btb_predictor_if.sv | 28 ++
 rtl/sat_counter2.sv | 13 +
 rtl/btb_predictor.sv | 73 +++++++
 4 files changed

// File: rtl/arm_bp_pkg.sv
// arm_bp_pkg: shared types and constants for the fetch-stage branch predictor
package arm_bp_pkg;

    typedef enum logic [1:0] {SNT, WNT, WT, ST} bp_cnt_t;

    // Tag is held zero-extended to 30 bits so the struct stays independent of BTB depth
    typedef struct packed {
        logic        valid;
        logic [29:0] tag;
        logic [29:0] target;
        bp_cnt_t     cnt;
    } btb_entry_t;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/btb_predictor_if.sv
// btb_predictor_if: fetch lookup, execute update and mispredict signals of the BTB
interface btb_predictor_if;
    logic [31:0] PCF;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        upd_valid_e;
    logic [31:0] upd_pc_e;
    logic        upd_taken_e;
    logic [31:0] upd_target_e;
    logic        upd_pred_taken_e;
    logic [31:0] upd_pred_tgt_e;
    logic        stall_e;
    logic        mispredict_e;
    logic [31:0] redirect_pc_e;
    logic [15:0] mispred_cnt;

    modport master (
        output PCF, upd_valid_e, upd_pc_e, upd_taken_e, upd_target_e,
               upd_pred_taken_e, upd_pred_tgt_e, stall_e,
        input  pred_taken_f, pred_target_f, mispredict_e, redirect_pc_e, mispred_cnt
    );

    modport slave (
        input  PCF, upd_valid_e, upd_pc_e, upd_taken_e, upd_target_e,
               upd_pred_taken_e, upd_pred_tgt_e, stall_e,
        output pred_taken_f, pred_target_f, mispredict_e, redirect_pc_e, mispred_cnt
    );
endinterface

// File: rtl/sat_counter2.sv
// sat_counter2: next state of a 2-bit saturating direction counter
module sat_counter2
    import arm_bp_pkg::*;
(
    input  bp_cnt_t cnt_i,
    input  logic    taken_i,
    output bp_cnt_t cnt_o
);
    always_comb begin
        cnt_o = taken_i ? ((cnt_i == ST) ? ST : bp_cnt_t'(cnt_i + 2'd1))
                        : ((cnt_i == SNT) ? SNT : bp_cnt_t'(cnt_i - 2'd1));
    end
endmodule

// File: rtl/btb_predictor.sv
// btb_predictor: flop-based BTB with 2-bit counters; combinational fetch lookup,
// execute-stage update, mispredict detection and a wrapping mispredict counter
module btb_predictor
    import arm_bp_pkg::*;
#(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned CNT_INIT = 1
) (
    input  logic           clk,
    input  logic           reset,
    btb_predictor_if.slave bp
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);

    btb_entry_t       tbl_q [ENTRIES];
    btb_entry_t       ent_d;
    btb_entry_t       f_ent;
    btb_entry_t       u_ent;
    logic [15:0]      mispred_cnt_q;
    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] u_idx;
    logic [29:0]      f_tag;
    logic [29:0]      u_tag;
    logic             f_hit;
    logic             u_hit;
    logic             upd_en;
    bp_cnt_t          cnt_nx;

    assign f_idx  = bp.PCF[IDX_W+1:2];
    assign f_tag  = 30'(bp.PCF[31:IDX_W+2]);
    assign u_idx  = bp.upd_pc_e[IDX_W+1:2];
    assign u_tag  = 30'(bp.upd_pc_e[31:IDX_W+2]);
    assign f_ent  = tbl_q[f_idx];
    assign u_ent  = tbl_q[u_idx];
    assign f_hit  = f_ent.valid && (f_ent.tag == f_tag);
    assign u_hit  = u_ent.valid && (u_ent.tag == u_tag);
    assign upd_en = bp.upd_valid_e && !bp.stall_e;

    // Lookup reads pre-update contents; a same-cycle update becomes visible next cycle
    assign bp.pred_taken_f  = !reset && f_hit && f_ent.cnt[1];
    assign bp.pred_target_f = bp.pred_taken_f ? {f_ent.target, 2'b00} : bp.PCF + PC_INC;
    assign bp.mispredict_e  = upd_en && ((bp.upd_taken_e != bp.upd_pred_taken_e) ||
                              (bp.upd_taken_e && (bp.upd_target_e != bp.upd_pred_tgt_e)));
    assign bp.redirect_pc_e = bp.upd_taken_e ? bp.upd_target_e : bp.upd_pc_e + PC_INC;
    assign bp.mispred_cnt   = mispred_cnt_q;

    sat_counter2 u_cnt (
        .cnt_i  (u_ent.cnt),
        .taken_i(bp.upd_taken_e),
        .cnt_o  (cnt_nx)
    );

    always_comb begin
        ent_d.valid  = 1'b1;
        ent_d.tag    = u_tag;
        ent_d.target = (u_hit && !bp.upd_taken_e) ? u_ent.target : bp.upd_target_e[31:2];
        ent_d.cnt    = u_hit ? cnt_nx : WT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                tbl_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: bp_cnt_t'(CNT_INIT[1:0])};
            mispred_cnt_q <= '0;
        end else begin
            // A not-taken miss leaves the table untouched
            if (upd_en && (u_hit || bp.upd_taken_e))
                tbl_q[u_idx] <= ent_d;
            if (bp.mispredict_e)
                mispred_cnt_q <= mispred_cnt_q + 16'd1;
        end
    end
endmodule
